// File: rtl/ex_mem_buffer.sv
// EX/MEM pipeline stage: 2-entry elastic buffer between the ALU and the memory stage.
// Define EX_MEM_FWD_EN to add the fwd_valid/fwd_dst/fwd_data forwarding outputs.
module ex_mem_buffer #(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5,
    parameter int unsigned CW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] R_Op,
    input  logic          ZF,
    input  logic [DW-1:0] wr_data,
    input  logic [RW-1:0] dst_reg,
    input  logic [DW-1:0] br_target,
    input  logic [CW-1:0] ctrl_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_alu,
    output logic          out_zf,
    output logic [DW-1:0] out_wdata,
    output logic [RW-1:0] out_dst,
    output logic [CW-1:0] out_ctrl,
    output logic [DW-1:0] out_br_target,
    output logic          br_taken,
    output logic [1:0]    occupancy
`ifdef EX_MEM_FWD_EN
    ,
    output logic          fwd_valid,
    output logic [RW-1:0] fwd_dst,
    output logic [DW-1:0] fwd_data
`endif
);

    localparam int unsigned DEPTH   = 2;
    localparam int unsigned BIT_BR  = 4;
    localparam int unsigned BIT_MRD = 3;
    localparam int unsigned BIT_RW  = 1;

    typedef struct packed {
        logic [DW-1:0] alu;
        logic          zf;
        logic [DW-1:0] wdata;
        logic [RW-1:0] dst;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] br;
    } entry_t;

    entry_t     r_mem [DEPTH];
    logic       r_head;
    logic       r_tail;
    logic [1:0] r_count;

    logic       w_push;
    logic       w_pop;
    entry_t     w_entry;
    entry_t     w_head;

    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign occupancy = r_count;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // Capture side-band; writes to r0 never carry RegWrite downstream.
    always_comb begin
        w_entry        = '0;
        w_entry.alu    = R_Op;
        w_entry.zf     = ZF;
        w_entry.wdata  = wr_data;
        w_entry.dst    = dst_reg;
        w_entry.ctrl   = ctrl_in;
        w_entry.br     = br_target;
        if (dst_reg == '0) begin
            w_entry.ctrl[BIT_RW] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= w_entry;
                r_tail        <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

    assign w_head        = r_mem[r_head];
    assign out_alu       = w_head.alu;
    assign out_zf        = w_head.zf;
    assign out_wdata     = w_head.wdata;
    assign out_dst       = w_head.dst;
    assign out_ctrl      = w_head.ctrl;
    assign out_br_target = w_head.br;
    assign br_taken      = out_valid & w_head.ctrl[BIT_BR] & w_head.zf;

`ifdef EX_MEM_FWD_EN
    entry_t w_young;
    logic   w_fwd;

    // Youngest entry sits one slot behind the tail.
    assign w_young   = r_mem[~r_tail];
    assign w_fwd     = out_valid & w_young.ctrl[BIT_RW] & ~w_young.ctrl[BIT_MRD];
    assign fwd_valid = w_fwd;
    assign fwd_dst   = w_fwd ? w_young.dst : '0;
    assign fwd_data  = w_fwd ? w_young.alu : '0;
`endif

endmodule
